pmem_arbiter: RTL and testbench

//  Shares one physical-memory port between the instruction-cache and data-cache controllers.
//  It sits between the two cache_control miss paths (allocate / write_back) and physical memory.

---
 rtl/pmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_pmem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//   Shares a single physical-memory port between the I-cache and D-cache miss
//   paths. Ownership is registered: once a side is granted, it keeps the port
//   until physical memory responds (or until it withdraws its request). While a
//   side owns the port, its strobes, address and write data pass straight
//   through to memory combinationally.
//
//   Tie-break between simultaneous requests is selected by RR:
//     RR = 1 : round-robin, the side that did not complete last wins
//     RR = 0 : fixed priority, the D-cache always wins
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   i_read, i_address      I-cache line-fill request
//   i_rdata, i_resp        fill data and completion pulse to the I-cache
//   d_read, d_write        D-cache fill / write-back request (both high = none)
//   d_address, d_wdata     D-cache line address and write-back line
//   d_rdata, d_resp        fill data and completion pulse to the D-cache
//   pmem_read, pmem_write  strobes to physical memory
//   pmem_address           physical line address
//   pmem_wdata             write-back line to physical memory
//   pmem_rdata, pmem_resp  read data and completion from physical memory
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // 1 when the D side completed the most recent transaction. Starts as D so
  // that the I side wins the first tie under round-robin.
  logic last_grant_d;
  logic last_grant_d_nxt;

  logic req_i;
  logic req_d;

  // A D request with both strobes high is malformed and counts as no request.
  assign req_i = i_read;
  assign req_d = d_read ^ d_write;

  // Fill data is broadcast; each cache qualifies it with its own resp.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
    end else begin
      state        <= state_nxt;
      last_grant_d <= last_grant_d_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    last_grant_d_nxt = last_grant_d;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    i_resp           = 1'b0;
    d_resp           = 1'b0;

    unique case (state)
      IDLE: begin
        // Memory is idle here, so pmem_resp is deliberately ignored.
        if (req_i && req_d) begin
          if (RR != 0) begin
            state_nxt = last_grant_d ? GRANT_I : GRANT_D;
          end else begin
            state_nxt = GRANT_D;
          end
        end else if (req_i) begin
          state_nxt = GRANT_I;
        end else if (req_d) begin
          state_nxt = GRANT_D;
        end
      end

      GRANT_I: begin
        pmem_read    = i_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        if (pmem_resp) begin
          state_nxt        = IDLE;
          last_grant_d_nxt = 1'b0;
        end else if (!req_i) begin
          state_nxt = IDLE;
        end
      end

      GRANT_D: begin
        // Gate the strobes with the decoded request so a malformed
        // read+write pair never reaches memory; it behaves as an abort.
        pmem_read    = d_read & ~d_write;
        pmem_write   = d_write & ~d_read;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        if (pmem_resp) begin
          state_nxt        = IDLE;
          last_grant_d_nxt = 1'b1;
        end else if (!req_d) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//   Two arbiters side by side: index 0 is round-robin, index 1 is fixed
//   D-priority. Each has its own request/response inputs; pmem_rdata is shared.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  always #5 clk = ~clk;

  logic         i_read       [2];
  logic [15:0]  i_address    [2];
  logic [127:0] i_rdata      [2];
  logic         i_resp       [2];
  logic         d_read       [2];
  logic         d_write      [2];
  logic [15:0]  d_address    [2];
  logic [127:0] d_wdata      [2];
  logic [127:0] d_rdata      [2];
  logic         d_resp       [2];
  logic         pmem_read    [2];
  logic         pmem_write   [2];
  logic [15:0]  pmem_address [2];
  logic [127:0] pmem_wdata   [2];
  logic [127:0] pmem_rdata;
  logic         pmem_resp    [2];

  int n_checks = 0;
  int n_pass   = 0;

  pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .RR(1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read[0]), .i_address(i_address[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_address(d_address[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
    .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]), .pmem_address(pmem_address[0]),
    .pmem_wdata(pmem_wdata[0]), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp[0])
  );

  pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .RR(0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read[1]), .i_address(i_address[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_address(d_address[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
    .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]), .pmem_address(pmem_address[1]),
    .pmem_wdata(pmem_wdata[1]), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model: who owns the port (0 none, 1 I, 2 D) and who finished last.
  // ---------------------------------------------------------------------------
  int m_owner  [2];
  bit m_last_d [2];

  function automatic int next_owner(int owner, bit last_d, int rr,
                                    bit ir, bit dr, bit dw, bit resp);
    bit wants_i;
    bit wants_d;
    wants_i = ir;
    wants_d = dr ^ dw;
    if (owner == 0) begin
      if (wants_i && wants_d) return (rr != 0 && last_d) ? 1 : 2;
      if (wants_i) return 1;
      if (wants_d) return 2;
      return 0;
    end
    if (resp) return 0;
    if (owner == 1) return wants_i ? 1 : 0;
    return wants_d ? 2 : 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner[0]  <= 0;
      m_owner[1]  <= 0;
      m_last_d[0] <= 1'b1;
      m_last_d[1] <= 1'b1;
    end else begin
      m_owner[0] <= next_owner(m_owner[0], m_last_d[0], 1, i_read[0], d_read[0], d_write[0], pmem_resp[0]);
      m_owner[1] <= next_owner(m_owner[1], m_last_d[1], 0, i_read[1], d_read[1], d_write[1], pmem_resp[1]);
      if (m_owner[0] != 0 && pmem_resp[0]) m_last_d[0] <= (m_owner[0] == 2);
      if (m_owner[1] != 0 && pmem_resp[1]) m_last_d[1] <= (m_owner[1] == 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      i_read[k]    = 1'b0;
      i_address[k] = '0;
      d_read[k]    = 1'b0;
      d_write[k]   = 1'b0;
      d_address[k] = '0;
      d_wdata[k]   = '0;
      pmem_resp[k] = 1'b0;
    end
    pmem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    i_read[0] = 1'b1; i_address[0] = 16'h0abc;
    d_write[1] = 1'b1; d_address[1] = 16'h0def; d_wdata[1] = {4{32'hdeadbeef}};
    pmem_resp[0] = 1'b1; pmem_resp[1] = 1'b1;
    tick();
    tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({pmem_read[k], pmem_write[k], i_resp[k], d_resp[k]} !== 4'b0000)
        $display("FAIL reset_ctl[%0d]: got rd/wr/iresp/dresp=%b want 0000", k,
                 {pmem_read[k], pmem_write[k], i_resp[k], d_resp[k]});
      else n_pass++;
      n_checks++;
      if (pmem_address[k] !== 16'h0 || pmem_wdata[k] !== 128'h0)
        $display("FAIL reset_bus[%0d]: got addr=%h wdata=%h want 0", k, pmem_address[k], pmem_wdata[k]);
      else n_pass++;
    end
    clear_inputs();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_i_fill();
    i_read[0] = 1'b1; i_address[0] = 16'h0040;
    #1;
    n_checks++;
    if (pmem_read[0] !== 1'b0)
      $display("FAIL ifill_idle: got pmem_read=%b want 0", pmem_read[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (pmem_read[0] !== 1'b1 || pmem_write[0] !== 1'b0 || pmem_address[0] !== 16'h0040)
      $display("FAIL ifill_grant: got rd=%b wr=%b addr=%h want 1 0 0040",
               pmem_read[0], pmem_write[0], pmem_address[0]);
    else n_pass++;
    pmem_rdata = {16{8'hA5}};
    pmem_resp[0] = 1'b1;
    #1;
    n_checks++;
    if (i_resp[0] !== 1'b1 || d_resp[0] !== 1'b0 || i_rdata[0] !== {16{8'hA5}})
      $display("FAIL ifill_resp: got iresp=%b dresp=%b rdata=%h want 1 0 a5..a5",
               i_resp[0], d_resp[0], i_rdata[0]);
    else n_pass++;
    tick();
    i_read[0] = 1'b0; pmem_resp[0] = 1'b0;
    #1;
    n_checks++;
    if (pmem_read[0] !== 1'b0 || i_resp[0] !== 1'b0)
      $display("FAIL ifill_dead: got rd=%b iresp=%b want 0 0", pmem_read[0], i_resp[0]);
    else n_pass++;
  endtask

  task automatic test_d_writeback();
    logic [127:0] wd;
    int held;
    wd = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    d_write[0] = 1'b1; d_address[0] = 16'h1230; d_wdata[0] = wd;
    tick();
    n_checks++;
    if (pmem_write[0] !== 1'b1 || pmem_read[0] !== 1'b0 ||
        pmem_address[0] !== 16'h1230 || pmem_wdata[0] !== wd)
      $display("FAIL dwb_grant: got wr=%b rd=%b addr=%h wdata=%h want 1 0 1230 %h",
               pmem_write[0], pmem_read[0], pmem_address[0], pmem_wdata[0], wd);
    else n_pass++;
    held = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (pmem_write[0] === 1'b1 && d_resp[0] === 1'b0 && pmem_address[0] === 16'h1230) held++;
    end
    n_checks++;
    if (held != 5)
      $display("FAIL dwb_hold: got %0d held cycles want 5", held);
    else n_pass++;
    pmem_resp[0] = 1'b1;
    #1;
    n_checks++;
    if (d_resp[0] !== 1'b1 || i_resp[0] !== 1'b0)
      $display("FAIL dwb_resp: got dresp=%b iresp=%b want 1 0", d_resp[0], i_resp[0]);
    else n_pass++;
    tick();
    d_write[0] = 1'b0; pmem_resp[0] = 1'b0;
    #1;
    n_checks++;
    if (pmem_write[0] !== 1'b0 || d_resp[0] !== 1'b0 || pmem_wdata[0] !== 128'h0)
      $display("FAIL dwb_idle: got wr=%b dresp=%b wdata=%h want 0 0 0",
               pmem_write[0], d_resp[0], pmem_wdata[0]);
    else n_pass++;
  endtask

  // Both sides hold a request; k selects the arbiter, order is the expected
  // sequence of owners (1 = I, 2 = D).
  task automatic test_ties(input int k, input int o0, input int o1, input int o2);
    int order[3];
    int exp_addr;
    order = '{o0, o1, o2};
    do_reset();
    i_read[k] = 1'b1; i_address[k] = 16'h0100;
    d_read[k] = 1'b1; d_address[k] = 16'h0200;
    for (int g = 0; g < 3; g++) begin
      tick();
      exp_addr = (order[g] == 1) ? 16'h0100 : 16'h0200;
      n_checks++;
      if (pmem_read[k] !== 1'b1 || pmem_address[k] !== 16'(exp_addr))
        $display("FAIL tie%0d_grant%0d: got rd=%b addr=%h want 1 %h",
                 k, g, pmem_read[k], pmem_address[k], 16'(exp_addr));
      else n_pass++;
      pmem_rdata = {4{$urandom}};
      pmem_resp[k] = 1'b1;
      #1;
      n_checks++;
      if (i_resp[k] !== (order[g] == 1) || d_resp[k] !== (order[g] == 2))
        $display("FAIL tie%0d_resp%0d: got iresp=%b dresp=%b want %b %b",
                 k, g, i_resp[k], d_resp[k], order[g] == 1, order[g] == 2);
      else n_pass++;
      tick();
      pmem_resp[k] = 1'b0;
      #1;
      n_checks++;
      if (pmem_read[k] !== 1'b0)
        $display("FAIL tie%0d_dead%0d: got rd=%b want 0", k, g, pmem_read[k]);
      else n_pass++;
    end
  endtask

  task automatic test_fixed_priority();
    test_ties(1, 2, 2, 2);
    // D drops out during the dead cycle; the waiting I request is then served.
    d_read[1] = 1'b0;
    tick();
    n_checks++;
    if (pmem_read[1] !== 1'b1 || pmem_address[1] !== 16'h0100)
      $display("FAIL fp_i_grant: got rd=%b addr=%h want 1 0100", pmem_read[1], pmem_address[1]);
    else n_pass++;
    pmem_resp[1] = 1'b1;
    #1;
    n_checks++;
    if (i_resp[1] !== 1'b1 || d_resp[1] !== 1'b0)
      $display("FAIL fp_i_resp: got iresp=%b dresp=%b want 1 0", i_resp[1], d_resp[1]);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_illegal_d();
    int strobes;
    do_reset();
    d_read[0] = 1'b1; d_write[0] = 1'b1; d_address[0] = 16'h0777;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (pmem_read[0] !== 1'b0 || pmem_write[0] !== 1'b0 || d_resp[0] !== 1'b0) strobes++;
    end
    n_checks++;
    if (strobes != 0)
      $display("FAIL illegal_d: got %0d active cycles want 0", strobes);
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    d_write[0] = 1'b1; d_address[0] = 16'h0880; d_wdata[0] = {4{32'h5a5a_0101}};
    tick();
    n_checks++;
    if (pmem_write[0] !== 1'b1)
      $display("FAIL midrst_pre: got wr=%b want 1", pmem_write[0]);
    else n_pass++;
    i_read[0] = 1'b1; i_address[0] = 16'h0990;
    #2;
    reset_n = 1'b0;
    pmem_resp[0] = 1'b1;
    #1;
    n_checks++;
    if (pmem_write[0] !== 1'b0 || pmem_read[0] !== 1'b0 || d_resp[0] !== 1'b0 || i_resp[0] !== 1'b0)
      $display("FAIL midrst_async: got wr=%b rd=%b dresp=%b iresp=%b want 0 0 0 0",
               pmem_write[0], pmem_read[0], d_resp[0], i_resp[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (pmem_write[0] !== 1'b0 || d_resp[0] !== 1'b0)
      $display("FAIL midrst_held: got wr=%b dresp=%b want 0 0", pmem_write[0], d_resp[0]);
    else n_pass++;
    reset_n = 1'b1;
    d_write[0] = 1'b0; pmem_resp[0] = 1'b0;
    tick();
    n_checks++;
    if (pmem_read[0] !== 1'b1 || pmem_address[0] !== 16'h0990)
      $display("FAIL midrst_regrant: got rd=%b addr=%h want 1 0990", pmem_read[0], pmem_address[0]);
    else n_pass++;
    pmem_resp[0] = 1'b1;
    #1;
    n_checks++;
    if (i_resp[0] !== 1'b1 || d_resp[0] !== 1'b0)
      $display("FAIL midrst_resp: got iresp=%b dresp=%b want 1 0", i_resp[0], d_resp[0]);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  // Random requesters and a random-latency memory on both arbiters, checked
  // every cycle against the reference model.
  task automatic test_random();
    bit           ibusy[2], dbusy[2], prev_iresp[2], prev_dresp[2];
    int           lat[2];
    int           iskip, dskip, max_skip;
    int           op;
    int           bad_port[2], bad_resp[2];
    logic         exp_rd, exp_wr, exp_ir, exp_dr;
    logic [15:0]  exp_ad;
    logic [127:0] exp_wd;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ibusy[k] = 0; dbusy[k] = 0; prev_iresp[k] = 0; prev_dresp[k] = 0;
      lat[k] = $urandom_range(0, 3); bad_port[k] = 0; bad_resp[k] = 0;
    end
    iskip = 0; dskip = 0; max_skip = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (ibusy[k] && (prev_iresp[k] || $urandom_range(0, 59) == 0)) begin
          ibusy[k] = 0; i_read[k] = 1'b0;
          if (k == 0) iskip = 0;
        end else if (!ibusy[k] && $urandom_range(0, 2) == 0) begin
          ibusy[k] = 1; i_read[k] = 1'b1; i_address[k] = 16'($urandom);
        end
        if (dbusy[k] && (prev_dresp[k] || $urandom_range(0, 59) == 0)) begin
          dbusy[k] = 0; d_read[k] = 1'b0; d_write[k] = 1'b0;
          if (k == 0) dskip = 0;
        end else if (!dbusy[k] && $urandom_range(0, 2) == 0) begin
          dbusy[k] = 1;
          op = $urandom_range(0, 19);
          d_read[k]  = (op == 0) || (op < 10);
          d_write[k] = (op == 0) || (op >= 10);
          d_address[k] = 16'($urandom);
          d_wdata[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        pmem_resp[k] = 1'b0;
      end
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      for (int k = 0; k < 2; k++) begin
        if (pmem_read[k] === 1'b1 || pmem_write[k] === 1'b1) begin
          if (lat[k] == 0) begin
            pmem_resp[k] = 1'b1;
            lat[k] = $urandom_range(0, 3);
          end else begin
            lat[k]--;
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        exp_rd = 1'b0; exp_wr = 1'b0; exp_ad = '0; exp_wd = '0; exp_ir = 1'b0; exp_dr = 1'b0;
        if (m_owner[k] == 1) begin
          exp_rd = i_read[k]; exp_ad = i_address[k]; exp_ir = pmem_resp[k];
        end else if (m_owner[k] == 2) begin
          exp_rd = d_read[k] & ~d_write[k];
          exp_wr = d_write[k] & ~d_read[k];
          exp_ad = d_address[k]; exp_wd = d_wdata[k]; exp_dr = pmem_resp[k];
        end
        n_checks++;
        if ({pmem_read[k], pmem_write[k], pmem_address[k], pmem_wdata[k]} !== {exp_rd, exp_wr, exp_ad, exp_wd}) begin
          if (bad_port[k] < 5)
            $display("FAIL rnd_port[%0d] cyc %0d: got rd=%b wr=%b addr=%h wdata=%h want %b %b %h %h",
                     k, c, pmem_read[k], pmem_write[k], pmem_address[k], pmem_wdata[k],
                     exp_rd, exp_wr, exp_ad, exp_wd);
          bad_port[k]++;
        end else n_pass++;
        n_checks++;
        if ({i_resp[k], d_resp[k]} !== {exp_ir, exp_dr} ||
            i_rdata[k] !== pmem_rdata || d_rdata[k] !== pmem_rdata) begin
          if (bad_resp[k] < 5)
            $display("FAIL rnd_resp[%0d] cyc %0d: got iresp=%b dresp=%b want %b %b (rdata i=%h d=%h want %h)",
                     k, c, i_resp[k], d_resp[k], exp_ir, exp_dr, i_rdata[k], d_rdata[k], pmem_rdata);
          bad_resp[k]++;
        end else n_pass++;
        prev_iresp[k] = (i_resp[k] === 1'b1);
        prev_dresp[k] = (d_resp[k] === 1'b1);
      end
      // Round-robin fairness: a waiting side sees at most one other completion.
      if (i_resp[0] === 1'b1) iskip = 0;
      else if (ibusy[0] && d_resp[0] === 1'b1) iskip++;
      if (d_resp[0] === 1'b1) dskip = 0;
      else if (dbusy[0] && (d_read[0] ^ d_write[0]) && i_resp[0] === 1'b1) dskip++;
      else if (dbusy[0] && !(d_read[0] ^ d_write[0])) dskip = 0;
      if (iskip > max_skip) max_skip = iskip;
      if (dskip > max_skip) max_skip = dskip;
    end
    n_checks++;
    if (max_skip > 1)
      $display("FAIL rr_fairness: got max wait of %0d other completions want <= 1", max_skip);
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_i_fill();
    test_d_writeback();
    test_ties(0, 1, 2, 1);
    clear_inputs();
    test_fixed_priority();
    test_illegal_d();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
